// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared load/store encodings, state and status codes
//
// Purpose: decoder-facing MEM_OP / MEM_SEL encodings plus the access-unit state
//          and completion-status codes, with legality/alignment helpers.
// Ports:   none (package).
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10
  } mem_op_e;

  // funct3 coding of the load/store width and signedness
  typedef enum logic [2:0] {
    SEL_B  = 3'b000,
    SEL_H  = 3'b001,
    SEL_W  = 3'b010,
    SEL_BU = 3'b100,
    SEL_HU = 3'b101
  } mem_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_REQ   = 2'b10,
    ST_RESP  = 2'b11
  } mau_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } mau_err_e;

  // Unsigned widths exist only for loads.
  function automatic logic sel_legal(input logic [1:0] op, input logic [2:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      SEL_B, SEL_H, SEL_W: ok = (op == OP_LOAD) || (op == OP_STORE);
      SEL_BU, SEL_HU:      ok = (op == OP_LOAD);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sel)
      SEL_H, SEL_HU: bad = off[0];
      SEL_W:         bad = (off != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-wide request/acknowledge memory bus
//
// Purpose: groups the memory-side bus of the access unit.
// Signals: bus_req, bus_we, bus_addr[31:0], bus_wstrb[3:0], bus_wdata[31:0]
//          (master to memory); bus_ack, bus_rdata[31:0] (memory to master).
// Modports: master (access unit), slave (memory).
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane steering and load extraction/extension
//
// Purpose: purely combinational byte-lane logic for a 32-bit word bus.
// Ports:   sel[2:0]       width/sign select (funct3 coding)
//          byte_off[1:0]  addr[1:0] of the access
//          st_data[31:0]  LSB-aligned store data
//          ld_raw[31:0]   raw word returned by the bus
//          wstrb[3:0]     byte enables for a store
//          wdata[31:0]    replicated store data
//          ld_data[31:0]  extracted, extended load result
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Replicating the data lets the strobe alone pick the lane.
  always_comb begin
    wstrb = 4'b1111;
    wdata = st_data;
    case (sel[1:0])
      2'b00: begin
        wstrb = 4'b0001 << byte_off;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << byte_off;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    shifted = ld_raw >> {byte_off, 3'b000};
    ld_data = 32'h0;
    case (sel)
      SEL_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      SEL_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      SEL_W:   ld_data = shifted;
      SEL_BU:  ld_data = {24'h0, shifted[7:0]};
      SEL_HU:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access sequencer with alignment checks and bus timeout
//
// Purpose: accepts one load/store from the pipeline, checks select legality and
//          alignment, runs a single request/acknowledge bus transfer with timeout
//          and returns a one-cycle completion pulse with status and load data.
// Ports:   clk, rst (sync, active-high)
//          start, mem_op[1:0], mem_sel[2:0], addr[31:0], wdata[31:0]  request
//          busy, done, rdata[31:0], err[1:0]                          completion
//          bus (mem_access_unit_if.master)                            memory bus
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e       state;
  logic [1:0]       op_q;
  logic [2:0]       sel_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  mem_lane_align u_lane (
    .sel      (sel_q),
    .byte_off (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_raw   (bus.bus_rdata),
    .wstrb    (lane_wstrb),
    .wdata    (lane_wdata),
    .ld_data  (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      op_q          <= 2'b00;
      sel_q         <= 3'b000;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata         <= 32'h0;
      err           <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (mem_op == OP_LOAD || mem_op == OP_STORE)) begin
            op_q    <= mem_op;
            sel_q   <= mem_sel;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            state   <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          // Illegal select outranks misalignment.
          if (!sel_legal(op_q, sel_q)) begin
            err   <= ERR_ILLEGAL;
            done  <= 1'b1;
            state <= ST_RESP;
          end else if (is_misaligned(sel_q, addr_q[1:0])) begin
            err   <= ERR_MISALIGN;
            done  <= 1'b1;
            state <= ST_RESP;
          end else begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= (op_q == OP_STORE);
            bus.bus_addr  <= {addr_q[31:2], 2'b00};
            bus.bus_wstrb <= (op_q == OP_STORE) ? lane_wstrb : 4'b0000;
            bus.bus_wdata <= (op_q == OP_STORE) ? lane_wdata : 32'h0;
            tmo_cnt       <= '0;
            state         <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Ack is tested first so an ack in the last counted cycle still succeeds.
          if (bus.bus_ack || (tmo_cnt == TMO_LAST)) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_wstrb <= 4'b0000;
            bus.bus_wdata <= 32'h0;
            tmo_cnt       <= '0;
            done          <= 1'b1;
            state         <= ST_RESP;
            if (bus.bus_ack) begin
              err   <= ERR_OK;
              rdata <= (op_q == OP_LOAD) ? lane_rdata : 32'h0;
            end else begin
              err   <= ERR_TIMEOUT;
              rdata <= 32'h0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          rdata <= 32'h0;
          err   <= ERR_OK;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mem_op;
  logic [2:0]  mem_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mem_op  (mem_op),
    .mem_sel (mem_sel),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .bus     (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns in the cycle after start (CHECK).
  task automatic issue(input logic [1:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; mem_op = op; mem_sel = sel; addr = a; wdata = d;
    tick();
    start = 1'b0; mem_op = OP_NOP; mem_sel = 3'b000; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (rdata !== 32'h0 || err !== 2'b00) begin errors++;
      $display("FAIL reset_rdata_err: got rdata=%h err=%b expected 0 00", rdata, err); end
    checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb} !== 6'b0 ||
                  bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_bus: got req=%b we=%b strb=%b addr=%h wdata=%h expected all 0",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lb();
    issue(OP_LOAD, SEL_B, 32'h0000_1003, 32'h0);
    checks++; if (busy !== 1'b1 || bus_if.bus_req !== 1'b0) begin errors++;
      $display("FAIL lb_check_cycle: got busy=%b req=%b expected 1 0", busy, bus_if.bus_req); end
    tick();
    checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h0000_1000) begin errors++;
      $display("FAIL lb_req: got req=%b addr=%h expected 1 00001000", bus_if.bus_req, bus_if.bus_addr); end
    checks++; if (bus_if.bus_we !== 1'b0 || bus_if.bus_wstrb !== 4'b0000) begin errors++;
      $display("FAIL lb_we_strb: got we=%b strb=%b expected 0 0000", bus_if.bus_we, bus_if.bus_wstrb); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80FF_FF00;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    checks++; if (done !== 1'b1 || rdata !== 32'hFFFF_FF80 || err !== 2'b00) begin errors++;
      $display("FAIL lb_done: got done=%b rdata=%h err=%b expected 1 ffffff80 00", done, rdata, err); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++;
      $display("FAIL lb_req_drop: got req=%b expected 0", bus_if.bus_req); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL lb_idle: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_sh();
    issue(OP_STORE, SEL_H, 32'h0000_2002, 32'h0000_BEEF);
    tick();
    checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 32'h0000_2000) begin errors++;
      $display("FAIL sh_req: got req=%b we=%b addr=%h expected 1 1 00002000",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr); end
    checks++; if (bus_if.bus_wstrb !== 4'b1100 || bus_if.bus_wdata !== 32'hBEEF_BEEF) begin errors++;
      $display("FAIL sh_lanes: got strb=%b wdata=%h expected 1100 beefbeef", bus_if.bus_wstrb, bus_if.bus_wdata); end
    tick();
    checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_wdata !== 32'hBEEF_BEEF || done !== 1'b0) begin errors++;
      $display("FAIL sh_hold: got req=%b wdata=%h done=%b expected 1 beefbeef 0",
               bus_if.bus_req, bus_if.bus_wdata, done); end
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 2'b00 || rdata !== 32'h0) begin errors++;
      $display("FAIL sh_done: got done=%b err=%b rdata=%h expected 1 00 0", done, err, rdata); end
    tick();
  endtask

  task automatic test_sb();
    issue(OP_STORE, SEL_B, 32'h0000_0101, 32'hFFFF_FFA5);
    tick();
    checks++; if (bus_if.bus_wstrb !== 4'b0010 || bus_if.bus_wdata !== 32'hA5A5_A5A5 ||
                  bus_if.bus_addr !== 32'h0000_0100) begin errors++;
      $display("FAIL sb_lanes: got strb=%b wdata=%h addr=%h expected 0010 a5a5a5a5 00000100",
               bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.bus_addr); end
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 2'b00) begin errors++;
      $display("FAIL sb_done: got done=%b err=%b expected 1 00", done, err); end
    tick();
  endtask

  task automatic test_misaligned();
    issue(OP_LOAD, SEL_W, 32'h0000_3001, 32'h0);
    checks++; if (done !== 1'b0 || bus_if.bus_req !== 1'b0) begin errors++;
      $display("FAIL mis_n1: got done=%b req=%b expected 0 0", done, bus_if.bus_req); end
    tick();
    checks++; if (done !== 1'b1 || err !== 2'b01 || rdata !== 32'h0 || bus_if.bus_req !== 1'b0) begin errors++;
      $display("FAIL mis_done: got done=%b err=%b rdata=%h req=%b expected 1 01 0 0",
               done, err, rdata, bus_if.bus_req); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL mis_idle: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    logic saw_done = 1'b0;
    logic [1:0] done_err = 2'b00;
    issue(OP_LOAD, SEL_HU, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 40 && !saw_done; i++) begin
      tick();
      if (bus_if.bus_req === 1'b1) req_cycles++;
      if (done === 1'b1) begin
        saw_done = 1'b1;
        done_err = err;
      end
    end
    checks++; if (saw_done !== 1'b1) begin errors++;
      $display("FAIL tmo_done: got done never seen within 40 cycles, expected a done pulse"); end
    checks++; if (req_cycles != 16) begin errors++;
      $display("FAIL tmo_req_len: got %0d bus_req cycles expected 16", req_cycles); end
    checks++; if (done_err !== 2'b10 || rdata !== 32'h0) begin errors++;
      $display("FAIL tmo_err: got err=%b rdata=%h expected 10 0", done_err, rdata); end
    tick();
  endtask

  task automatic test_ack_last();
    issue(OP_LOAD, SEL_BU, 32'h0000_8002, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++;
      $display("FAIL last_req: got req=%b in 16th REQ cycle expected 1", bus_if.bus_req); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h00C3_0000;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    checks++; if (done !== 1'b1 || err !== 2'b00 || rdata !== 32'h0000_00C3) begin errors++;
      $display("FAIL last_ack: got done=%b err=%b rdata=%h expected 1 00 000000c3", done, err, rdata); end
    tick();
  endtask

  task automatic test_illegal_and_busy();
    int dones = 0;
    logic any_req = 1'b0;
    issue(OP_STORE, 3'b100, 32'h0000_0010, 32'h0000_0055);
    start = 1'b1; mem_op = OP_LOAD; mem_sel = SEL_W; addr = 32'h0000_0020;
    tick();
    checks++; if (done !== 1'b1 || err !== 2'b11 || rdata !== 32'h0) begin errors++;
      $display("FAIL ill_done: got done=%b err=%b rdata=%h expected 1 11 0", done, err, rdata); end
    dones = 1;
    tick();
    start = 1'b0; mem_op = OP_NOP; mem_sel = 3'b000; addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      if (bus_if.bus_req === 1'b1) any_req = 1'b1;
      tick();
    end
    checks++; if (dones != 1 || any_req !== 1'b0) begin errors++;
      $display("FAIL ill_busy_start: got %0d done pulses req_seen=%b expected 1 0", dones, any_req); end
  endtask

  task automatic test_nop();
    int dones = 0;
    issue(OP_NOP, SEL_W, 32'h0000_0040, 32'h0);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL nop_busy: got busy=%b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++; if (dones != 0) begin errors++;
      $display("FAIL nop_done: got %0d done pulses expected 0", dones); end
  endtask

  task automatic test_rst_in_req();
    int dones = 0;
    issue(OP_LOAD, SEL_W, 32'h0000_5000, 32'h0);
    tick();
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++;
      $display("FAIL rst_pre_req: got req=%b expected 1", bus_if.bus_req); end
    rst = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    checks++; if (bus_if.bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL rst_abort: got req=%b busy=%b done=%b expected 0 0 0", bus_if.bus_req, busy, done); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++;
      $display("FAIL rst_no_done: got %0d done pulses expected 0", dones); end
    issue(OP_LOAD, SEL_W, 32'h0000_6004, 32'h0);
    tick();
    checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h0000_6004) begin errors++;
      $display("FAIL rst_next_req: got req=%b addr=%h expected 1 00006004", bus_if.bus_req, bus_if.bus_addr); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    checks++; if (done !== 1'b1 || err !== 2'b00 || rdata !== 32'h1234_5678) begin errors++;
      $display("FAIL rst_next_done: got done=%b err=%b rdata=%h expected 1 00 12345678", done, err, rdata); end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_op = OP_NOP; mem_sel = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    test_reset();
    test_lb();
    test_sh();
    test_sb();
    test_misaligned();
    test_timeout();
    test_ack_last();
    test_illegal_and_busy();
    test_nop();
    test_rst_in_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
